// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-stream, line-buffer/window and gradient-core signals of the Sobel frame
// sequencer. The controller uses the slave view; its environment uses the master view.
interface sobel_frame_ctrl_if #(
   parameter int MAX_PIXEL_BITS = 8,
   parameter int COL_BITS       = 5
);
   logic                      frame_start_i;
   logic                      px_valid_i;
   logic [MAX_PIXEL_BITS-1:0] px_data_i;
   logic                      px_ready_o;
   logic                      lb_wr_en_o;
   logic [COL_BITS-1:0]       lb_addr_o;
   logic [MAX_PIXEL_BITS-1:0] lb_data_o;
   logic                      win_shift_o;
   logic                      sobel_start_o;
   logic                      sobel_done_i;
   logic [MAX_PIXEL_BITS-1:0] sobel_px_i;
   logic                      out_valid_o;
   logic [MAX_PIXEL_BITS-1:0] out_px_o;
   logic                      overrun_o;
   logic                      timeout_o;
   logic                      frame_done_o;

   modport slave (
      input  frame_start_i, px_valid_i, px_data_i, sobel_done_i, sobel_px_i,
      output px_ready_o, lb_wr_en_o, lb_addr_o, lb_data_o, win_shift_o,
             sobel_start_o, out_valid_o, out_px_o, overrun_o, timeout_o, frame_done_o
   );

   modport master (
      output frame_start_i, px_valid_i, px_data_i, sobel_done_i, sobel_px_i,
      input  px_ready_o, lb_wr_en_o, lb_addr_o, lb_data_o, win_shift_o,
             sobel_start_o, out_valid_o, out_px_o, overrun_o, timeout_o, frame_done_o
   );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the SPI pixel receiver and the Sobel datapath: one output
// pixel per input pixel, zero on borders, gradient core result for interior pixels.
module sobel_frame_ctrl #(
   parameter int MAX_PIXEL_BITS = 8,
   parameter int IMG_WIDTH      = 32,
   parameter int IMG_HEIGHT     = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int COL_BITS       = $clog2(IMG_WIDTH),
   parameter int ROW_BITS       = $clog2(IMG_HEIGHT)
) (
   input logic               clk_i,
   input logic               nreset_i,
   sobel_frame_ctrl_if.slave bus
);

   localparam int TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(IMG_WIDTH - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(IMG_HEIGHT - 1);
   localparam logic [COL_BITS-1:0] COL_INNER = COL_BITS'(2);
   localparam logic [ROW_BITS-1:0] ROW_INNER = ROW_BITS'(2);
   localparam logic [TO_BITS-1:0]  TO_LAST   = TO_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_PX,
      S_SHIFT,
      S_COMPUTE,
      S_WAIT_DONE,
      S_OUTPUT,
      S_FRAME_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [COL_BITS-1:0]       col_q, col_d;
   logic [ROW_BITS-1:0]       row_q, row_d;
   logic [MAX_PIXEL_BITS-1:0] px_q, px_d;
   logic [TO_BITS-1:0]        to_cnt_q, to_cnt_d;
   logic [MAX_PIXEL_BITS-1:0] out_px_q, out_px_d;
   logic                      overrun_q, overrun_d;
   logic                      timeout_q, timeout_d;
   logic                      ready_q, ready_d;
   logic                      shift_q, shift_d;
   logic                      start_q, start_d;
   logic                      out_valid_q, out_valid_d;
   logic                      frame_done_q, frame_done_d;

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves it unassigned (no latch).
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      px_d      = px_q;
      to_cnt_d  = to_cnt_q;
      out_px_d  = out_px_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;

      if (bus.frame_start_i) begin
         // Frame start beats everything, including a coincident pixel.
         state_d   = S_WAIT_PX;
         col_d     = '0;
         row_d     = '0;
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end else begin
         if (bus.px_valid_i && (state_q != S_IDLE) && (state_q != S_WAIT_PX)) begin
            overrun_d = 1'b1;
         end

         unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_WAIT_PX: begin
               if (bus.px_valid_i) begin
                  px_d    = bus.px_data_i;
                  state_d = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if ((row_q >= ROW_INNER) && (col_q >= COL_INNER)) begin
                  state_d = S_COMPUTE;
               end else begin
                  out_px_d = '0;
                  state_d  = S_OUTPUT;
               end
            end
            S_COMPUTE: begin
               to_cnt_d = '0;
               state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (bus.sobel_done_i) begin
                  out_px_d = bus.sobel_px_i;
                  state_d  = S_OUTPUT;
               end else if (to_cnt_q == TO_LAST) begin
                  timeout_d = 1'b1;
                  out_px_d  = '0;
                  state_d   = S_OUTPUT;
               end else begin
                  to_cnt_d = to_cnt_q + TO_BITS'(1);
               end
            end
            S_OUTPUT: begin
               state_d = S_WAIT_PX;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = S_FRAME_DONE;
                  end else begin
                     row_d = row_q + ROW_BITS'(1);
                  end
               end else begin
                  col_d = col_q + COL_BITS'(1);
               end
            end
            S_FRAME_DONE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
         endcase
      end

      // Strobes are decoded from the next state so they are registered with it.
      ready_d      = (state_d == S_WAIT_PX);
      shift_d      = (state_d == S_SHIFT);
      start_d      = (state_d == S_COMPUTE);
      out_valid_d  = (state_d == S_OUTPUT);
      frame_done_d = (state_d == S_FRAME_DONE);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         px_q         <= '0;
         to_cnt_q     <= '0;
         out_px_q     <= '0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
         ready_q      <= 1'b0;
         shift_q      <= 1'b0;
         start_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         px_q         <= px_d;
         to_cnt_q     <= to_cnt_d;
         out_px_q     <= out_px_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
         ready_q      <= ready_d;
         shift_q      <= shift_d;
         start_q      <= start_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // The column counter doubles as the line-buffer address during the shift cycle.
   assign bus.px_ready_o    = ready_q;
   assign bus.lb_wr_en_o    = shift_q;
   assign bus.win_shift_o   = shift_q;
   assign bus.lb_addr_o     = col_q;
   assign bus.lb_data_o     = px_q;
   assign bus.sobel_start_o = start_q;
   assign bus.out_valid_o   = out_valid_q;
   assign bus.out_px_o      = out_px_q;
   assign bus.overrun_o     = overrun_q;
   assign bus.timeout_o     = timeout_q;
   assign bus.frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x4 frame: stimulus pushes expected
// shifts, core starts and output pixels; monitor and core model pop and compare.
module tb_sobel_frame_ctrl;
   localparam int PB = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int TO = 64;
   localparam int CB = $clog2(W);
   localparam int RB = $clog2(H);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_frame_ctrl_if #(.MAX_PIXEL_BITS(PB), .COL_BITS(CB)) bus ();

   sobel_frame_ctrl #(
      .MAX_PIXEL_BITS(PB), .IMG_WIDTH(W), .IMG_HEIGHT(H),
      .TIMEOUT_CYCLES(TO), .COL_BITS(CB), .ROW_BITS(RB)
   ) u_dut (
      .clk_i(clk),
      .nreset_i(rst_n),
      .bus(bus)
   );

   typedef struct { int addr; int data; int cyc; } shift_exp_t;
   typedef struct { int cyc; bit answer; int delay; int val; } start_exp_t;
   // kind: 0 border, 1 core answered, 2 core timed out
   typedef struct { int val; int kind; int t; bit last; } out_exp_t;

   shift_exp_t shq[$];
   start_exp_t stq[$];
   out_exp_t   outq[$];

   int checks = 0, failures = 0;
   int cyc = 0, done_cyc = 0, done_exp_cyc = 0;
   int frames_done = 0, outs_seen = 0;
   bit pending_done = 1'b0;
   bit exp_overrun = 1'b0, exp_timeout = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor: line-buffer shifts, output pixels and frame-done pulses.
   shift_exp_t mon_se;
   out_exp_t   mon_oe;
   int         mon_exp_cyc;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.lb_wr_en_o) begin
            if (shq.size() == 0) check("shift_unexpected", 1, 0);
            else begin
               mon_se = shq.pop_front();
               check("shift_addr", 32'(bus.lb_addr_o), mon_se.addr);
               check("shift_data", 32'(bus.lb_data_o), mon_se.data);
               check("shift_cyc", cyc, mon_se.cyc);
               check("win_shift", 32'(bus.win_shift_o), 1);
            end
         end
         if (pending_done && cyc == done_exp_cyc) begin
            check("frame_done", 32'(bus.frame_done_o), 1);
            if (bus.frame_done_o) frames_done++;
            pending_done = 1'b0;
         end else if (bus.frame_done_o) begin
            check("frame_done_unexpected", 1, 0);
         end
         if (bus.out_valid_o) begin
            if (outq.size() == 0) check("out_unexpected", 1, 0);
            else begin
               mon_oe = outq.pop_front();
               outs_seen++;
               check("out_px", 32'(bus.out_px_o), mon_oe.val);
               case (mon_oe.kind)
                  0:       mon_exp_cyc = mon_oe.t + 2;
                  1:       mon_exp_cyc = done_cyc + 1;
                  default: mon_exp_cyc = mon_oe.t + 3 + TO;
               endcase
               check("out_cyc", cyc, mon_exp_cyc);
               if (mon_oe.last) begin
                  pending_done = 1'b1;
                  done_exp_cyc = cyc + 1;
               end
            end
         end
      end
   end

   // Gradient-core model: answers ~pixel after the requested delay, or never.
   start_exp_t rsp_e;
   always @(negedge clk) begin
      if (rst_n && bus.sobel_start_o) begin
         if (stq.size() == 0) check("start_unexpected", 1, 0);
         else begin
            rsp_e = stq.pop_front();
            check("start_cyc", cyc, rsp_e.cyc);
            if (rsp_e.answer) begin
               repeat (rsp_e.delay) @(negedge clk);
               bus.sobel_done_i = 1'b1;
               bus.sobel_px_i   = PB'(rsp_e.val);
               done_cyc         = cyc;
               @(negedge clk);
               bus.sobel_done_i = 1'b0;
               bus.sobel_px_i   = PB'($urandom);
            end
         end
      end
   end

   task automatic start_frame(input bit with_px);
      @(negedge clk);
      bus.frame_start_i = 1'b1;
      if (with_px) begin
         bus.px_valid_i = 1'b1;
         bus.px_data_i  = PB'($urandom);
      end
      shq.delete();
      stq.delete();
      outq.delete();
      pending_done = 1'b0;
      exp_overrun  = 1'b0;
      exp_timeout  = 1'b0;
      @(negedge clk);
      bus.frame_start_i = 1'b0;
      bus.px_valid_i    = 1'b0;
      check("ready_after_start", 32'(bus.px_ready_o), 1);
      check("overrun_clear", 32'(bus.overrun_o), 0);
      check("timeout_clear", 32'(bus.timeout_o), 0);
   endtask

   task automatic wait_signal_start();
      int n = 0;
      while (!bus.sobel_start_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.sobel_start_o) check("start_wait_expired", 0, 1);
   endtask

   task automatic send_px(input int r, input int c, input int data,
                          input bit withhold, input int delay, input int gap);
      int n = 0;
      int t, val, kind;
      repeat (gap) @(negedge clk);
      while (!bus.px_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.px_ready_o) begin
         check("ready_wait_expired", 0, 1);
         return;
      end
      bus.px_valid_i = 1'b1;
      bus.px_data_i  = PB'(data);
      t = cyc;
      shq.push_back('{addr: c, data: data, cyc: t + 1});
      if (r >= 2 && c >= 2) begin
         stq.push_back('{cyc: t + 2, answer: !withhold, delay: delay, val: (~data) & 'hFF});
         val  = withhold ? 0 : ((~data) & 'hFF);
         kind = withhold ? 2 : 1;
         if (withhold) exp_timeout = 1'b1;
      end else begin
         val  = 0;
         kind = 0;
      end
      outq.push_back('{val: val, kind: kind, t: t, last: (r == H - 1 && c == W - 1)});
      @(negedge clk);
      bus.px_valid_i = 1'b0;
      bus.px_data_i  = PB'($urandom);
   endtask

   task automatic run_frame(input int n_pix, input bit rnd, input int timeout_idx,
                            input int edge_idx, input int overrun_idx, input int abort_idx);
      int n;
      for (int i = 0; i < n_pix; i++) begin
         int data, gap, delay;
         data  = rnd ? int'($urandom_range(0, 255)) : ('h10 + i);
         gap   = rnd ? int'($urandom_range(0, 3)) : 6;
         delay = rnd ? int'($urandom_range(1, 6)) : 1;
         if (i == edge_idx) delay = TO;
         if (i == overrun_idx) delay = 5;
         send_px(i / W, i % W, data, (i == timeout_idx || i == abort_idx), delay, gap);
         if (i == overrun_idx) begin
            wait_signal_start();
            @(negedge clk);
            bus.px_valid_i = 1'b1;
            bus.px_data_i  = PB'($urandom);
            @(negedge clk);
            bus.px_valid_i = 1'b0;
            exp_overrun    = 1'b1;
            check("overrun_set", 32'(bus.overrun_o), 1);
         end
         if (i == abort_idx) begin
            wait_signal_start();
            repeat (3) @(negedge clk);
            start_frame(1'b0);
            return;
         end
      end
      n = 0;
      while ((outq.size() != 0 || pending_done) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(outq.size()) + 32'(pending_done), 0);
      check("overrun_flag", 32'(bus.overrun_o), 32'(exp_overrun));
      check("timeout_flag", 32'(bus.timeout_o), 32'(exp_timeout));
   endtask

   initial begin
      bus.frame_start_i = 1'b0;
      bus.px_valid_i    = 1'b0;
      bus.px_data_i     = '0;
      bus.sobel_done_i  = 1'b0;
      bus.sobel_px_i    = '0;
      repeat (3) @(negedge clk);
      check("reset_strobes", {bus.px_ready_o, bus.lb_wr_en_o, bus.win_shift_o, bus.sobel_start_o,
                              bus.out_valid_o, bus.frame_done_o, bus.overrun_o, bus.timeout_o}, 0);
      check("reset_data", {bus.lb_addr_o, bus.lb_data_o, bus.out_px_o}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_not_ready", 32'(bus.px_ready_o), 0);

      // A pixel in idle is ignored without raising overrun.
      bus.px_valid_i = 1'b1;
      bus.px_data_i  = PB'(8'h55);
      @(negedge clk);
      bus.px_valid_i = 1'b0;
      @(negedge clk);
      check("idle_px_no_overrun", 32'(bus.overrun_o), 0);

      // Frame A: ramp 0x10..0x1F, core answers one cycle after start.
      start_frame(1'b0);
      run_frame(16, 1'b0, -1, -1, -1, -1);
      check("frames_after_a", frames_done, 1);
      check("idle_after_frame", 32'(bus.px_ready_o), 0);

      // Frame B: start with coincident pixel, overrun, one core timeout.
      start_frame(1'b1);
      run_frame(16, 1'b1, 11, -1, 10, -1);
      check("frames_after_b", frames_done, 2);

      // Frame C aborted in the wait for the core; frame D follows the abort.
      start_frame(1'b0);
      run_frame(16, 1'b1, -1, -1, -1, 10);
      run_frame(16, 1'b1, -1, 14, -1, -1);
      check("frames_after_d", frames_done, 3);

      // Frame E interrupted by reset, then a clean frame F.
      start_frame(1'b0);
      run_frame(5, 1'b1, -1, -1, -1, -1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_strobes", {bus.px_ready_o, bus.lb_wr_en_o, bus.win_shift_o, bus.sobel_start_o,
                                 bus.out_valid_o, bus.frame_done_o, bus.overrun_o, bus.timeout_o}, 0);
      check("midreset_data", {bus.lb_addr_o, bus.lb_data_o, bus.out_px_o}, 0);
      shq.delete();
      stq.delete();
      outq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_frame(1'b0);
      run_frame(16, 1'b1, -1, -1, -1, -1);
      check("frames_total", frames_done, 4);
      check("outputs_total", outs_seen, 16 + 16 + 10 + 16 + 5 + 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
